// File: rtl/ctrl_pipe.sv
// ctrl_pipe: merges hold requesters, bus hold and ex jump into per-stage
// hold/flush vectors, with a one-entry pending jump replayed after bus hold.
// Params: STAGES (stage 0 = pc), NUM_SRC, ADDR_W; DW is derived.
// Ports: clk, rst (sync, active high), hold_req_i, hold_depth_i,
//   jump_flag_i, jump_addr_i, bus_hold_flag_i -> hold_o, flush_o,
//   jump_flag_o, jump_addr_o, jump_pending_o.
// Option: CTRL_PIPE_PERF_EN adds saturating stall_cnt_o / flush_cnt_o.
module ctrl_pipe #(
   parameter int STAGES  = 3,
   parameter int NUM_SRC = 2,
   parameter int ADDR_W  = 32,
   localparam int DW     = $clog2(STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_SRC-1:0]    hold_req_i,
   input  logic [NUM_SRC*DW-1:0] hold_depth_i,
   input  logic                  jump_flag_i,
   input  logic [ADDR_W-1:0]     jump_addr_i,
   input  logic                  bus_hold_flag_i,
   output logic [STAGES-1:0]     hold_o,
   output logic [STAGES-1:0]     flush_o,
   output logic                  jump_flag_o,
   output logic [ADDR_W-1:0]     jump_addr_o,
   output logic                  jump_pending_o
`ifdef CTRL_PIPE_PERF_EN
   ,
   output logic [31:0]           stall_cnt_o,
   output logic [31:0]           flush_cnt_o
`endif
);

   // every stage behind pc is flushed on a redirect
   localparam logic [STAGES-1:0] FLUSH_MASK =
      {STAGES{1'b1}} ^ STAGES'(1);

   typedef enum logic {IDLE, PEND} state_t;

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [DW-1:0]       dep;
   logic [DW-1:0]       dep_k;
   logic [STAGES-1:0]   hold_dep;

   // deepest clamped request wins; bus hold counts as depth 1
   always_comb begin
      dep   = DW'(bus_hold_flag_i);
      dep_k = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         dep_k = hold_depth_i[k*DW +: DW];
         if (dep_k > DW'(STAGES))
            dep_k = DW'(STAGES);
         if (hold_req_i[k] && (dep_k > dep))
            dep = dep_k;
      end
   end

   always_comb begin
      hold_dep = '0;
      for (int i = 0; i < STAGES; i++)
         hold_dep[i] = (i < int'(dep));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && jump_flag_i && bus_hold_flag_i)
            addr_q <= jump_addr_i;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (jump_flag_i && bus_hold_flag_i)
               state_d = PEND;
         PEND:
            if (!bus_hold_flag_i)
               state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   always_comb begin
      hold_o         = '0;
      flush_o        = '0;
      jump_flag_o    = 1'b0;
      jump_addr_o    = '0;
      jump_pending_o = 1'b0;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               unique case (1'b1)
                  (jump_flag_i && !bus_hold_flag_i): begin
                     jump_flag_o = 1'b1;
                     jump_addr_o = jump_addr_i;
                     flush_o     = FLUSH_MASK;
                  end
                  // jump captured; pc waits for the bus
                  (jump_flag_i && bus_hold_flag_i): begin
                     hold_o  = STAGES'(1);
                     flush_o = FLUSH_MASK;
                  end
                  default:
                     hold_o = hold_dep;
               endcase
            end
            PEND: begin
               jump_pending_o = 1'b1;
               if (bus_hold_flag_i) begin
                  hold_o = '1;
               end else begin
                  jump_flag_o = 1'b1;
                  jump_addr_o = addr_q;
                  flush_o     = FLUSH_MASK;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CTRL_PIPE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (hold_o[0] && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 32'd1;
         if (jump_flag_o && (flush_cnt_o != '1))
            flush_cnt_o <= flush_cnt_o + 32'd1;
      end
   end
`else
   // no performance counters in this build
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed and random checks of ctrl_pipe against a
// behavioural model of the hold/flush/jump rules.
module tb_ctrl_pipe;
   localparam int STAGES  = 3;
   localparam int NUM_SRC = 2;
   localparam int ADDR_W  = 32;
   localparam int DW      = $clog2(STAGES + 1);

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_SRC-1:0]    hold_req_i;
   logic [NUM_SRC*DW-1:0] hold_depth_i;
   logic                  jump_flag_i;
   logic [ADDR_W-1:0]     jump_addr_i;
   logic                  bus_hold_flag_i;
   logic [STAGES-1:0]     hold_o;
   logic [STAGES-1:0]     flush_o;
   logic                  jump_flag_o;
   logic [ADDR_W-1:0]     jump_addr_o;
   logic                  jump_pending_o;
`ifdef CTRL_PIPE_PERF_EN
   logic [31:0]           stall_cnt_o;
   logic [31:0]           flush_cnt_o;
`endif

   ctrl_pipe #(
      .STAGES (STAGES),
      .NUM_SRC(NUM_SRC),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .hold_req_i     (hold_req_i),
      .hold_depth_i   (hold_depth_i),
      .jump_flag_i    (jump_flag_i),
      .jump_addr_i    (jump_addr_i),
      .bus_hold_flag_i(bus_hold_flag_i),
      .hold_o         (hold_o),
      .flush_o        (flush_o),
      .jump_flag_o    (jump_flag_o),
      .jump_addr_o    (jump_addr_o),
      .jump_pending_o (jump_pending_o)
`ifdef CTRL_PIPE_PERF_EN
      ,
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   bit                m_pend = 1'b0;
   bit                m_init = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [31:0]       m_stall = '0;
   logic [31:0]       m_flush = '0;

   logic [STAGES-1:0] e_hold;
   logic [STAGES-1:0] e_flush;
   logic              e_jf;
   logic [ADDR_W-1:0] e_ja;
   logic              e_pend;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_out();
      int d;
      int v;
      logic [STAGES-1:0] mask;
      mask    = '1;
      mask[0] = 1'b0;
      e_hold  = '0;
      e_flush = '0;
      e_jf    = 1'b0;
      e_ja    = '0;
      e_pend  = 1'b0;
      d = bus_hold_flag_i ? 1 : 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         v = int'(hold_depth_i[k*DW +: DW]);
         if (v > STAGES) v = STAGES;
         if (hold_req_i[k] && v > d) d = v;
      end
      if (rst) begin
      end else if (m_pend) begin
         e_pend = 1'b1;
         if (bus_hold_flag_i) begin
            e_hold = '1;
         end else begin
            e_jf    = 1'b1;
            e_ja    = m_addr;
            e_flush = mask;
         end
      end else if (jump_flag_i && !bus_hold_flag_i) begin
         e_jf    = 1'b1;
         e_ja    = jump_addr_i;
         e_flush = mask;
      end else if (jump_flag_i) begin
         e_hold  = STAGES'(1);
         e_flush = mask;
      end else begin
         e_hold = STAGES'((1 << d) - 1);
      end
   endfunction

   function automatic void model_step();
      if (rst) begin
         m_pend  = 1'b0;
         m_addr  = '0;
         m_stall = '0;
         m_flush = '0;
         m_init  = 1'b1;
      end else begin
         if (m_pend) begin
            if (!bus_hold_flag_i) m_pend = 1'b0;
         end else if (jump_flag_i && bus_hold_flag_i) begin
            m_pend = 1'b1;
            m_addr = jump_addr_i;
         end
         if (e_hold[0] && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (e_jf && m_flush != 32'hFFFF_FFFF) m_flush++;
      end
   endfunction

   task automatic cyc();
      @(negedge clk);
      model_out();
      chk("m_hold", 32'(hold_o), 32'(e_hold));
      chk("m_flush", 32'(flush_o), 32'(e_flush));
      chk("m_jf", 32'(jump_flag_o), 32'(e_jf));
      chk("m_ja", jump_addr_o, e_ja);
      chk("m_pend", 32'(jump_pending_o), 32'(e_pend));
`ifdef CTRL_PIPE_PERF_EN
      if (m_init) begin
         chk("m_stall_cnt", stall_cnt_o, m_stall);
         chk("m_flush_cnt", flush_cnt_o, m_flush);
      end
`endif
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic r, input logic [NUM_SRC-1:0] req,
                         input logic [NUM_SRC*DW-1:0] dep,
                         input logic jf, input logic [ADDR_W-1:0] ja,
                         input logic bus);
      rst             = r;
      hold_req_i      = req;
      hold_depth_i    = dep;
      jump_flag_i     = jf;
      jump_addr_i     = ja;
      bus_hold_flag_i = bus;
      #1;
   endtask

   int pulses;

   initial begin
      set_in(1, '1, '1, 1, 32'hDEAD_BEEF, 1);
      @(posedge clk);
      #1;
      // reset with every input active
      chk("rst_hold", 32'(hold_o), 0);
      chk("rst_flush", 32'(flush_o), 0);
      chk("rst_jf", 32'(jump_flag_o), 0);
      chk("rst_ja", jump_addr_o, 0);
      chk("rst_pend", 32'(jump_pending_o), 0);
      cyc();
      cyc();
      // depth merge
      set_in(0, 2'b11, {2'd2, 2'd1}, 0, 0, 0);
      chk("dm_011", 32'(hold_o), 32'b011);
      cyc();
      set_in(0, 2'b11, {2'd3, 2'd1}, 0, 0, 0);
      chk("dm_max", 32'(hold_o), 32'b111);
      cyc();
      set_in(0, 2'b00, {2'd3, 2'd3}, 0, 0, 1);
      chk("dm_bus", 32'(hold_o), 32'b001);
      cyc();
      // direct jump beats a depth-3 hold
      set_in(0, 2'b01, {2'd0, 2'd3}, 1, 32'h100, 0);
      chk("dj_jf", 32'(jump_flag_o), 1);
      chk("dj_ja", jump_addr_o, 32'h100);
      chk("dj_flush", 32'(flush_o), 32'b110);
      chk("dj_hold", 32'(hold_o), 32'b000);
      cyc();
      // deferred jump
      set_in(0, 0, 0, 1, 32'h200, 1);
      chk("df_cap_hold", 32'(hold_o), 32'b001);
      chk("df_cap_flush", 32'(flush_o), 32'b110);
      chk("df_cap_jf", 32'(jump_flag_o), 0);
      cyc();
      repeat (3) begin
         set_in(0, 0, 0, 0, 0, 1);
         chk("df_pend", 32'(jump_pending_o), 1);
         chk("df_pend_hold", 32'(hold_o), 32'b111);
         cyc();
      end
      set_in(0, 0, 0, 0, 0, 0);
      chk("df_rel_jf", 32'(jump_flag_o), 1);
      chk("df_rel_ja", jump_addr_o, 32'h200);
      chk("df_rel_flush", 32'(flush_o), 32'b110);
      cyc();
      chk("df_after_pend", 32'(jump_pending_o), 0);
      chk("df_after_jf", 32'(jump_flag_o), 0);
      cyc();
      // second jump during pend is ignored
      pulses = 0;
      set_in(0, 0, 0, 1, 32'h300, 1);
      cyc();
      set_in(0, 0, 0, 1, 32'h400, 1);
      chk("sj_pend_jf", 32'(jump_flag_o), 0);
      chk("sj_pend", 32'(jump_pending_o), 1);
      cyc();
      set_in(0, 0, 0, 0, 0, 0);
      chk("sj_ja", jump_addr_o, 32'h300);
      if (jump_flag_o) pulses++;
      cyc();
      if (jump_flag_o) pulses++;
      cyc();
      chk("sj_pulses", 32'(pulses), 1);
      // reset while pending
      set_in(0, 0, 0, 1, 32'h500, 1);
      cyc();
      set_in(1, 0, 0, 0, 0, 1);
      chk("rp_rst_pend", 32'(jump_pending_o), 0);
      chk("rp_rst_jf", 32'(jump_flag_o), 0);
      cyc();
      set_in(0, 0, 0, 0, 0, 0);
      chk("rp_jf", 32'(jump_flag_o), 0);
      chk("rp_pend", 32'(jump_pending_o), 0);
`ifdef CTRL_PIPE_PERF_EN
      chk("rp_stall_cnt", stall_cnt_o, 0);
      chk("rp_flush_cnt", flush_cnt_o, 0);
`endif
      cyc();
      // random traffic against the model
      repeat (400) begin
         set_in($urandom_range(0, 39) == 0,
                NUM_SRC'($urandom),
                (NUM_SRC*DW)'($urandom),
                $urandom_range(0, 3) == 0,
                $urandom,
                $urandom_range(0, 2) == 0);
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
